div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the EX stage. Services DIV/DIVU; stalling of EX is handled by EX/CTRL.
- EX holds start_i high with stable operands until ready_o rises.
- The result is then taken as the {HI,LO} pair and travels down the pipeline's hi/lo path.
- Radix-2 restoring algorithm: one quotient bit per clock.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit_step.sv | 32 +++
 rtl/div_unit.sv | 179 +++++++++++++++++
 tb/tb_div_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider.
// Contents:
//   div_state_e          - divider FSM state codes (2 bits)
//   DIV_START / DIV_STOP - levels of the start request line
//   DIV_RESULT_READY /
//   DIV_RESULT_NOT_READY - levels of the ready line
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   work_i    [2*DATA_W-1:0]  {partial remainder, remaining dividend / quotient bits}
//   divisor_i [DATA_W-1:0]    divisor magnitude
//   work_o    [2*DATA_W-1:0]  working value after one shift / trial-subtract
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] work_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] work_o
);

  // Upper DATA_W+1 bits of the working value after a left shift by one.
  logic [DATA_W:0] upper;
  logic [DATA_W:0] diff;
  logic            no_borrow;

  always_comb begin
    upper     = work_i[2*DATA_W-1:DATA_W-1];
    diff      = upper - {1'b0, divisor_i};
    // The partial remainder is always below the divisor, so a borrow shows
    // up in the top bit of the DATA_W+1-bit difference.
    no_borrow = ~diff[DATA_W];
    if (no_borrow) begin
      work_o = {diff[DATA_W-1:0], work_i[DATA_W-2:0], 1'b1};
    end else begin
      work_o = {upper[DATA_W-1:0], work_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule : div_unit_step

// File: rtl/div_unit.sv
// Multi-cycle integer divider (DIV / DIVU) for the EX stage.
// Radix-2 restoring algorithm, one quotient bit per clock.
//
// Handshake: EX raises start_i with stable operands and keeps it high until
// it has consumed the result. ready_o marks result_o valid; the result is
// held while start_i stays high, and both clear on the edge after start_i
// drops (or annul_i rises). start_i falling during the iteration phase
// aborts the operation just like annul_i. A new request is accepted only
// from FREE, so back-to-back operations cost one idle cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-low
//   signed_div_i  1 = signed DIV, 0 = DIVU (sampled at accept)
//   opdata1_i     dividend (sampled at accept)
//   opdata2_i     divisor  (sampled at accept)
//   start_i       request, held until the result is consumed
//   annul_i       abort the in-flight division
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//   dbg_state_o   current FSM state (observation only)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output div_state_e          dbg_state_o
);

  localparam logic [DATA_W-1:0] ONE_W    = DATA_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return (~v) + ONE_W;
  endfunction

  div_state_e          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                sign_q_q,  sign_q_d;
  logic                sign_r_q,  sign_r_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [2*DATA_W-1:0] work_q,    work_d;
  logic [2*DATA_W-1:0] result_q,  result_d;
  logic                ready_q,   ready_d;

  logic [2*DATA_W-1:0] work_step;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  div_unit_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  // Operand magnitudes; 0x80000000 negates to itself and is then read as
  // unsigned, which gives the defined result for the most-negative case.
  always_comb begin
    mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? negate(opdata1_i) : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? negate(opdata2_i) : opdata2_i;
  end

  // Sign fix-up of the final iteration's output.
  always_comb begin
    quo_fix = sign_q_q ? negate(work_step[DATA_W-1:0]) : work_step[DATA_W-1:0];
    rem_fix = sign_r_q ? negate(work_step[2*DATA_W-1:DATA_W])
                       : work_step[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;
    divisor_d = divisor_q;
    work_d    = work_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            divisor_d = mag2;
            work_d    = {{DATA_W{1'b0}}, mag1};
            sign_q_d  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            sign_r_d  = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end

      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i || start_i == DIV_STOP) begin
          // Partial result is dropped; result_o keeps its previous value.
          state_d = DIV_FREE;
          cnt_d   = '0;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q + ONE_C;
          if (cnt_q == LAST_CNT) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {rem_fix, quo_fix};
          end
        end
      end

      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      divisor_q <= '0;
      work_q    <= '0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
      divisor_q <= divisor_d;
      work_q    <= work_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  div_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  div_unit #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // DIV/DIVU semantics: quotient truncates toward zero, remainder takes the
  // dividend's sign; divide by zero gives all zeros. Computed in 64 bits so
  // the most-negative / -1 case wraps to 0x80000000 naturally.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Raises start with the given operands and waits (bounded) for ready.
  // Operands are scrambled after the accept edge: the divider must ignore them.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int edges);
    signed_div = sg;
    op1        = a;
    op2        = b;
    annul      = 1'b0;
    start      = 1'b1;
    edges      = 0;
    while (edges < 40) begin
      tick();
      edges++;
      op1        = $urandom();
      op2        = $urandom();
      signed_div = 1'($urandom_range(0, 1));
      if (ready) break;
    end
    res = result;
  endtask

  task automatic release_start();
    start = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || dbg_state !== DIV_FREE) begin
      errors++;
      $display("FAIL reset: ready=%b result=%h state=%s, want 0/0/FREE",
               ready, result, dbg_state.name());
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] res;
    int          n;
    run_div(1'b0, 32'd100, 32'd7, res, n);
    checks++;
    if (n !== 33 || ready !== 1'b1) begin
      errors++;
      $display("FAIL udiv_latency: edges=%0d ready=%b, want 33/1", n, ready);
    end
    checks++;
    if (res !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL udiv_100_7: got %h want %h", res, {32'd2, 32'd14});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
        errors++;
        $display("FAIL udiv_hold: ready=%b result=%h want 1/%h", ready, result,
                 {32'd2, 32'd14});
      end
    end
    release_start();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || dbg_state !== DIV_FREE) begin
      errors++;
      $display("FAIL udiv_release: ready=%b result=%h state=%s want 0/0/FREE",
               ready, result, dbg_state.name());
    end
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int          n;
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, res, n);
    checks++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || n !== 33) begin
      errors++;
      $display("FAIL sdiv_m7_2: got %h edges=%0d want %h edges=33", res, n,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    release_start();
    run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, res, n);
    checks++;
    if (res !== {32'h0000_0001, 32'hFFFF_FFFD} || n !== 33) begin
      errors++;
      $display("FAIL sdiv_7_m2: got %h edges=%0d want %h edges=33", res, n,
               {32'h0000_0001, 32'hFFFF_FFFD});
    end
    release_start();
  endtask

  task automatic test_div_zero();
    signed_div = 1'b0; op1 = 32'd5; op2 = 32'd0; annul = 1'b0; start = 1'b1;
    tick();
    checks++;
    if (dbg_state !== DIV_BYZERO || ready !== 1'b0) begin
      errors++;
      $display("FAIL divzero_edge1: state=%s ready=%b want BYZERO/0",
               dbg_state.name(), ready);
    end
    tick();
    checks++;
    if (dbg_state !== DIV_END || ready !== 1'b1 || result !== 64'd0) begin
      errors++;
      $display("FAIL divzero_edge2: state=%s ready=%b result=%h want END/1/0",
               dbg_state.name(), ready, result);
    end
    release_start();
    checks++;
    if (dbg_state !== DIV_FREE || ready !== 1'b0) begin
      errors++;
      $display("FAIL divzero_release: state=%s ready=%b want FREE/0",
               dbg_state.name(), ready);
    end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int          n;
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; annul = 1'b0; start = 1'b1;
    tick();                             // accept
    for (int i = 0; i < 10; i++) tick(); // ten iterations done
    annul = 1'b1;
    tick();
    checks++;
    if (dbg_state !== DIV_FREE || ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL annul: state=%s ready=%b result=%h want FREE/0/0",
               dbg_state.name(), ready, result);
    end
    annul = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL annul_no_ready: cycle %0d ready=%b want 0", i, ready);
      end
    end
    run_div(1'b0, 32'd9, 32'd3, res, n);
    checks++;
    if (res !== {32'd0, 32'd3} || n !== 33) begin
      errors++;
      $display("FAIL annul_then_9_3: got %h edges=%0d want %h edges=33", res, n,
               {32'd0, 32'd3});
    end
    release_start();
  endtask

  task automatic test_sync_reset();
    logic [63:0] res;
    int          n;
    signed_div = 1'b0; op1 = 32'd77; op2 = 32'd5; annul = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    #2;
    checks++;
    if (dbg_state !== DIV_ON) begin
      errors++;
      $display("FAIL rst_not_async_on: state=%s want ON", dbg_state.name());
    end
    tick();
    checks++;
    if (dbg_state !== DIV_FREE || ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_div: state=%s ready=%b result=%h want FREE/0/0",
               dbg_state.name(), ready, result);
    end
    rst = 1'b1;
    start = 1'b0;
    tick();
    run_div(1'b0, 32'd77, 32'd5, res, n);
    checks++;
    if (res !== {32'd2, 32'd15}) begin
      errors++;
      $display("FAIL rst_recover_77_5: got %h want %h", res, {32'd2, 32'd15});
    end
    rst = 1'b0;
    #2;
    checks++;
    if (ready !== 1'b1 || dbg_state !== DIV_END) begin
      errors++;
      $display("FAIL rst_not_async_end: ready=%b state=%s want 1/END",
               ready, dbg_state.name());
    end
    tick();
    checks++;
    if (dbg_state !== DIV_FREE || ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL rst_in_end: state=%s ready=%b result=%h want FREE/0/0",
               dbg_state.name(), ready, result);
    end
    rst = 1'b1;
    start = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    logic [63:0] res;
    int          n;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, n);
    checks++;
    if (res !== {32'h0000_0000, 32'h8000_0000}) begin
      errors++;
      $display("FAIL sdiv_min_m1: got %h want %h", res, {32'h0, 32'h8000_0000});
    end
    release_start();
    run_div(1'b0, 32'd3, 32'hFFFF_FFFF, res, n);
    checks++;
    if (res !== {32'd3, 32'd0}) begin
      errors++;
      $display("FAIL udiv_3_max: got %h want %h", res, {32'd3, 32'd0});
    end
    release_start();
    run_div(1'b1, 32'hFFFF_FFFD, 32'd10, res, n);  // -3 / 10
    checks++;
    if (res !== {32'hFFFF_FFFD, 32'd0}) begin
      errors++;
      $display("FAIL sdiv_small: got %h want %h", res, {32'hFFFF_FFFD, 32'd0});
    end
    release_start();
  endtask

  // Randomized back-to-back operations with random hold times.
  task automatic test_random();
    logic [63:0] res;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic        sg;
    logic [31:0] a, b;
    int          n, exp_n;
    for (int t = 0; t < 60; t++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom();
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = $urandom(); end
        default: b = $urandom() >> $urandom_range(0, 31);
      endcase
      exp_q.push_back(ref_div(sg, a, b));
      exp_n = (b == 32'd0) ? 2 : 33;
      run_div(sg, a, b, res, n);
      exp_v = exp_q.pop_front();
      checks++;
      if (res !== exp_v || n !== exp_n) begin
        errors++;
        $display("FAIL rand_%0d: s=%b %h/%h got %h edges=%0d want %h edges=%0d",
                 t, sg, a, b, res, n, exp_v, exp_n);
      end
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) tick();
      release_start();
      checks++;
      if (ready !== 1'b0 || result !== 64'd0) begin
        errors++;
        $display("FAIL rand_release_%0d: ready=%b result=%h want 0/0", t, ready, result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_sync_reset();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_unit
